// File: rtl/higher_memory_arbiter.sv
// Round-robin arbiter sharing one higher-memory channel between two cache-side
// requesters; one transaction in flight, fields latched at grant.

package higher_memory_arbiter_pkg;
  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_operation_e;
endpackage

module higher_memory_arbiter
  import higher_memory_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [XLEN-1:0]   p0_req_address,
  input  memory_operation_e p0_req_operation,
  input  logic [XLEN-1:0]   p0_req_store_word,
  input  logic              p0_req_valid,
  output logic [XLEN-1:0]   p0_req_loaded_word,
  output logic              p0_req_fulfilled,

  input  logic [XLEN-1:0]   p1_req_address,
  input  memory_operation_e p1_req_operation,
  input  logic [XLEN-1:0]   p1_req_store_word,
  input  logic              p1_req_valid,
  output logic [XLEN-1:0]   p1_req_loaded_word,
  output logic              p1_req_fulfilled,

  output logic [XLEN-1:0]   mem_req_address,
  output memory_operation_e mem_req_operation,
  output logic [XLEN-1:0]   mem_req_store_word,
  output logic              mem_req_valid,
  input  logic [XLEN-1:0]   mem_req_loaded_word,
  input  logic              mem_req_fulfilled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e state;
  logic   grant;       // port owning the current transaction
  logic   last_grant;  // port granted most recently
  logic   winner;

  // On a tie the port not granted last wins; otherwise the lone requester wins.
  always_comb begin
    winner = 1'b0;
    if (p0_req_valid && p1_req_valid) winner = ~last_grant;
    else if (p1_req_valid)            winner = 1'b1;
  end

  // NOTE: every register here, outputs included, uses non-blocking assignment so
  // all state updates see pre-edge values; the async reset also drops
  // mem_req_valid immediately when a transaction is abandoned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      grant              <= 1'b0;
      last_grant         <= 1'b1;
      mem_req_address    <= '0;
      mem_req_operation  <= MEM_LOAD;
      mem_req_store_word <= '0;
      mem_req_valid      <= 1'b0;
      p0_req_loaded_word <= '0;
      p1_req_loaded_word <= '0;
      p0_req_fulfilled   <= 1'b0;
      p1_req_fulfilled   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req_valid || p1_req_valid) begin
            grant         <= winner;
            mem_req_valid <= 1'b1;
            state         <= BUSY;
            if (winner) begin
              mem_req_address    <= p1_req_address;
              mem_req_operation  <= p1_req_operation;
              mem_req_store_word <= p1_req_store_word;
            end else begin
              mem_req_address    <= p0_req_address;
              mem_req_operation  <= p0_req_operation;
              mem_req_store_word <= p0_req_store_word;
            end
          end
        end

        BUSY: begin
          if (mem_req_fulfilled) begin
            mem_req_valid <= 1'b0;
            last_grant    <= grant;
            state         <= RESPOND;
            // The loaded word is captured on stores as well as loads.
            if (grant) begin
              p1_req_loaded_word <= mem_req_loaded_word;
              p1_req_fulfilled   <= 1'b1;
            end else begin
              p0_req_loaded_word <= mem_req_loaded_word;
              p0_req_fulfilled   <= 1'b1;
            end
          end
        end

        RESPOND: begin
          p0_req_fulfilled <= 1'b0;
          p1_req_fulfilled <= 1'b0;
          state            <= IDLE;
        end

        default: begin
          p0_req_fulfilled <= 1'b0;
          p1_req_fulfilled <= 1'b0;
          mem_req_valid    <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/higher_memory_arbiter.md
# higher_memory_arbiter

Two-port arbiter that shares one higher-memory channel between two cache-side requesters, for example the instruction-cache and data-cache miss/writeback ports. It sits between the caches' higher-memory request ports and the single higher-memory interface. Grants are round-robin, and it carries one transaction at a time. Request fields are registered at grant; the response is registered and returned only to the granted requester.

## Interface
Parameters
- XLEN, 32, address and data width.

Ports
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req_address / p1_req_address  in  XLEN  requester address.
- p0_req_operation / p1_req_operation  in  memory_operation_e  requester operation.
- p0_req_store_word / p1_req_store_word  in  XLEN  requester store data.
- p0_req_valid / p1_req_valid  in  1  request pending; held until fulfilled.
- p0_req_loaded_word / p1_req_loaded_word  out  XLEN  returned load data.
- p0_req_fulfilled / p1_req_fulfilled  out  1  one-cycle completion pulse.
- mem_req_address  out  XLEN  to higher memory.
- mem_req_operation  out  memory_operation_e  to higher memory.
- mem_req_store_word  out  XLEN  to higher memory.
- mem_req_valid  out  1  request to higher memory.
- mem_req_loaded_word  in  XLEN  from higher memory.
- mem_req_fulfilled  in  1  completion from higher memory.

## Operation
- State machine: IDLE, BUSY, RESPOND.
- **IDLE**
  - If any pN_req_valid is high, select a winner, latch its address, operation and store word into the mem_req_* registers, and record grant. Next state is BUSY.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Single request: it wins.
  - Both requests high: the port not granted last wins.
  - The last-grant pointer updates on entry to RESPOND.
  - The pointer resets so that port 0 wins the first tie.
- **BUSY**
  - mem_req_valid is 1 and the mem_req_* fields are stable.
  - On mem_req_fulfilled = 1, latch mem_req_loaded_word into the granted port's loaded-word register. Next state is RESPOND.
- **RESPOND**
  - The granted port's pN_req_fulfilled is 1 for exactly one cycle.
  - mem_req_valid is 0.
  - Next state is IDLE.
- **Ungranted port:** fulfilled stays 0 and its loaded word is unchanged.
- **Loaded-word registers:** each pN_req_loaded_word holds its last value until that port's next response. The latch happens on stores too.
- **Request withdrawal:** if the granted requester drops valid mid-transaction, it is ignored. The transaction completes from the latched fields and the fulfilled pulse is still issued.
- **Spurious completion:** mem_req_fulfilled in IDLE or RESPOND is ignored, with no state or output change.
- **Requester inputs outside IDLE:** sampled only in IDLE. A request arriving while another is BUSY waits in IDLE for arbitration.

## Timing
- **Reset:** reset_n low immediately forces:
  - state to IDLE;
  - last-grant pointer to port 1 (so port 0 wins the first tie);
  - all outputs to 0: mem_req_valid, mem_req_address, mem_req_store_word, pN_req_fulfilled, pN_req_loaded_word;
  - mem_req_operation to enum value 0.
- **Reset mid-transaction:** the transaction is abandoned, no fulfilled pulse is issued, and mem_req_valid drops asynchronously.
- **Latency:** with valid seen in IDLE at cycle 0:
  - mem_req_valid is high from cycle 1;
  - memory fulfilled at cycle k (k ≥ 1) gives pN_req_fulfilled at cycle k+1;
  - the earliest next grant is sampled at cycle k+2;
  - minimum round trip is 2 cycles, and memory is idle for 2 cycles between back-to-back transactions.
- **Requester rule:** the requester deasserts or changes its request after sampling fulfilled. A valid still high in the following IDLE cycle is treated as a new request.
- **Memory rule:** the memory's fulfilled pulse is one cycle and may arrive in the first BUSY cycle.

## Test plan
- **Reset:** assert reset_n = 0 mid-BUSY with p0 granted and address 0x1000 -> all outputs 0 in the same cycle; after release, idle with no pulse to p0.
- **Single load:** p0 load from address 0x0000_0040; memory fulfils 3 cycles after mem_req_valid rises with 0xDEAD_BEEF -> p0_req_loaded_word = 0xDEAD_BEEF and p0_req_fulfilled pulses once; p1 outputs unchanged.
- **Simultaneous requests from reset:** p0 = 0x100, p1 = 0x200 (store 0x1234_5678) -> memory sees 0x100 then 0x200 with store word 0x1234_5678; the fulfilled pulses arrive in order p0, p1.
- **Round-robin under saturation:** both ports hold valid continuously for 6 transactions -> grants alternate p0, p1, p0, p1, p0, p1; no starvation.
- **Withdrawal:** p1 drops valid one cycle after grant -> memory fields unchanged until fulfilled; p1_req_fulfilled still pulses once.
- **Spurious completion:** mem_req_fulfilled = 1 while IDLE -> no fulfilled pulse, no state change; the next request proceeds normally with 2-cycle minimum latency.
